ldl_capture: RTL

Synchronous capture stage directly downstream of the LDL asynchronous handshake cell on the LDL input GPIO path. Synchronises the cell's `ask` request, samples the bundled `data_in` word into a small FIFO and drives `latched` back to the C-element, completing the four-phase handshake. The FIFO is drained by the Wishbone register side through a simple read strobe.

---
 rtl/ldl_pkg.sv | 20 ++
 rtl/ldl_capture_sync2.sv | 25 ++
 rtl/ldl_capture.sv | 109 ++++++++++
 3 files changed

// File: rtl/ldl_pkg.sv
// Shared definitions for the LDL capture path: FSM encoding, default sizes
// and a constant-evaluable log2 helper.
package ldl_pkg;

  localparam int LDL_DW    = 8;
  localparam int LDL_DEPTH = 4;

  typedef enum logic {
    LDL_IDLE   = 1'b0,
    LDL_WAIT_C = 1'b1
  } ldl_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/ldl_capture_sync2.sv
// Two-flop synchroniser (module sync2) for asynchronous single-bit inputs;
// clears to 0 on the asynchronous active-low reset.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ldl_capture.sv
// Capture stage behind the LDL handshake cell: synchronised ask, one word per
// four-phase handshake into a small FIFO. Optional irq via LDL_CAPTURE_IRQ_EN.
module ldl_capture
  import ldl_pkg::*;
#(
  parameter int DW    = LDL_DW,
  parameter int DEPTH = LDL_DEPTH
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic                   ask,
  input  logic [DW-1:0]          data_in,
  output logic                   latched,
  input  logic                   rd_en,
  output logic [DW-1:0]          rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [clog2(DEPTH):0]  count,
  output logic                   irq
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  ldl_state_e        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [DW-1:0]     rd_data_q;
  logic [DW-1:0]     mem [DEPTH];
  logic              ask_s;
  logic              wr_en;
  logic              rd_fire;
  logic              full_w;
  logic              empty_w;

  sync2 u_ask_sync (
    .clk_i  (wb_clk_i),
    .rst_ni (reset),
    .d_i    (ask),
    .q_o    (ask_s)
  );

  // Capture decision uses the registered count, so a pop frees a slot for the next edge.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    full_w  = (count_q == FULL_COUNT);
    empty_w = (count_q == '0);
    case (state_q)
      LDL_IDLE: begin
        if (ask_s && !full_w) begin
          wr_en   = 1'b1;
          state_d = LDL_WAIT_C;
        end
      end
      LDL_WAIT_C: begin
        if (!ask_s) state_d = LDL_IDLE;
      end
      default: state_d = LDL_IDLE;
    endcase
    rd_fire = rd_en && !empty_w;
    count_d = count_q;
    if (wr_en && !rd_fire)      count_d = count_q + CW'(1);
    else if (!wr_en && rd_fire) count_d = count_q - CW'(1);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge wb_clk_i or negedge reset) begin
    if (!reset) begin
      state_q   <= LDL_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_fire) begin
        rd_data_q <= mem[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign latched = (state_q == LDL_WAIT_C);
  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);

`ifdef LDL_CAPTURE_IRQ_EN
  logic irq_q;

  always_ff @(posedge wb_clk_i or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= (count_q != '0);
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
